// File: rtl/demux2_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux2_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_ALT = 1'b1
    } demux_mode_t;

endpackage : demux2_pkg

// File: rtl/demux2_stream_chan_fifo2.sv
// Two-entry in-order register FIFO for one output channel.
// The head entry is a register of its own, so the channel data output comes straight from a flop.
module chan_fifo2
    import demux2_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [W-1:0]     tail;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the entries are reset because the channel data output must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (empty) head <= data;
                    else       tail <= data;
                    count <= count + CNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - CNT_W'(1);
                end
                2'b11: begin
                    // Count is unchanged; with one entry the new beat becomes the head.
                    if (full) begin
                        head <= tail;
                        tail <= data;
                    end else begin
                        head <= data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : chan_fifo2

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: routes each accepted beat to a buffered channel
// chosen by in_sel or, in alternate mode, by an internal toggle, and counts beats per channel.
module demux2_stream
    import demux2_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_sel,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [W-1:0]  out0_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [W-1:0]  out1_data,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    demux_mode_t mode_e;
    logic        tp;
    logic        target;
    logic        accept;
    logic [1:0]  push;
    logic [1:0]  full;
    logic [1:0]  empty;

    assign mode_e = demux_mode_t'(mode);

    // in_ready depends only on registered FIFO state and the routing inputs, never on out*_ready.
    always_comb begin
        target   = (mode_e == MODE_ALT) ? tp : in_sel;
        in_ready = !full[target];
        accept   = in_valid && in_ready;
        push     = '0;
        push[target] = accept;
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp   <= 1'b0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push[0]) cnt0 <= cnt0 + CW'(1);
            if (push[1]) cnt1 <= cnt1 + CW'(1);
            // A stalled beat leaves tp alone, so alternation is never broken.
            if (mode_e == MODE_SEL) tp <= 1'b0;
            else if (accept)        tp <= ~tp;
        end
    end

    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];

    chan_fifo2 #(.W(W)) u_chan0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push[0]),
        .pop   (out0_valid && out0_ready),
        .data  (in_data),
        .full  (full[0]),
        .empty (empty[0]),
        .head  (out0_data)
    );

    chan_fifo2 #(.W(W)) u_chan1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push[1]),
        .pop   (out1_valid && out1_ready),
        .data  (in_data),
        .full  (full[1]),
        .empty (empty[1]),
        .head  (out1_data)
    );

endmodule : demux2_stream

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a queue-based reference model.
module tb_demux2_stream;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out0_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [W-1:0]  out1_data;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int checks = 0;
    int errors = 0;

    demux2_stream #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queues, beat counters and the alternation bit.
    logic [W-1:0] mq [2][$];
    int           mc [2];
    int           mtp;
    bit           live = 1'b0;
    int           m_t;
    bit           m_acc;

    always @(posedge clk) begin
        if (rst) begin
            mq[0].delete();
            mq[1].delete();
            mc[0] = 0;
            mc[1] = 0;
            mtp   = 0;
            live  = 1'b1;
        end else if (live) begin
            m_t   = mode ? mtp : int'(in_sel);
            m_acc = in_valid && (mq[m_t].size() < 2);
            if (out0_ready && mq[0].size() > 0) void'(mq[0].pop_front());
            if (out1_ready && mq[1].size() > 0) void'(mq[1].pop_front());
            if (m_acc) begin
                mq[m_t].push_back(in_data);
                mc[m_t] = (mc[m_t] + 1) % (1 << CW);
            end
            if (!mode)      mtp = 0;
            else if (m_acc) mtp = 1 - mtp;
        end
    end

    // Compare process: one cycle's worth of outputs against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        int exp_t;
        #1;
        if (live) begin
            exp_t = mode ? mtp : int'(in_sel);
            check("in_ready", 32'(in_ready), 32'(mq[exp_t].size() < 2));
            check("out0_valid", 32'(out0_valid), 32'(mq[0].size() > 0));
            check("out1_valid", 32'(out1_valid), 32'(mq[1].size() > 0));
            if (mq[0].size() > 0) check("out0_data", 32'(out0_data), 32'(mq[0][0]));
            if (mq[1].size() > 0) check("out1_data", 32'(out1_data), 32'(mq[1][0]));
            check("cnt0", 32'(cnt0), 32'(mc[0]));
            check("cnt1", 32'(cnt1), 32'(mc[1]));
        end
    end

    task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                        input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(posedge clk);
        #2;
    endtask

    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst out0_valid", 32'(out0_valid), 32'd0);
        check("rst out1_valid", 32'(out1_valid), 32'd0);
        check("rst out0_data", 32'(out0_data), 32'd0);
        check("rst out1_data", 32'(out1_data), 32'd0);
        check("rst cnt0", 32'(cnt0), 32'd0);
        check("rst cnt1", 32'(cnt1), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // SEL routing
        step(1, 0, 8'h11, 1, 1);
        check("sel out0_data", 32'(out0_data), 32'h11);
        check("sel cnt0", 32'(cnt0), 32'd1);
        step(1, 1, 8'h22, 1, 1);
        check("sel out1_data", 32'(out1_data), 32'h22);
        check("sel cnt1", 32'(cnt1), 32'd1);
        check("sel out0 popped", 32'(out0_valid), 32'd0);

        // Backpressure fill on ch0
        step(1, 0, 8'hA0, 0, 1);
        check("bp ready after 1", 32'(in_ready), 32'd1);
        step(1, 0, 8'hA1, 0, 1);
        check("bp ready after 2", 32'(in_ready), 32'd0);
        step(1, 0, 8'hA2, 0, 1);
        check("bp ready stays low", 32'(in_ready), 32'd0);
        check("bp head held", 32'(out0_data), 32'hA0);
        check("bp cnt0", 32'(cnt0), 32'd3);

        // Channel independence: ch0 full, ch1 beat still accepted
        step(1, 1, 8'h55, 0, 0);
        check("indep out1_valid", 32'(out1_valid), 32'd1);
        check("indep out1_data", 32'(out1_data), 32'h55);

        // Release ch0: A0 popped, then A2 accepted behind A1
        step(1, 0, 8'hA2, 1, 1);
        check("bp pop A1 head", 32'(out0_data), 32'hA1);
        check("bp ready back", 32'(in_ready), 32'd1);
        step(1, 0, 8'hA2, 1, 1);
        check("bp A2 head", 32'(out0_data), 32'hA2);
        check("bp cnt0 wrapped", 32'(cnt0), 32'd0);
        step(0, 0, 8'h00, 1, 1);

        // ALT de-interleave
        mode = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1, 0, W'(i), 1, 1);
            if (i % 2 == 1) check("alt out0_data", 32'(out0_data), 32'(i));
            else            check("alt out1_data", 32'(out1_data), 32'(i));
        end
        // Stall ch1: 0x0A must wait for ch1 and ch0 must stay unused
        step(1, 0, 8'h07, 1, 0);
        step(1, 0, 8'h08, 1, 0);
        step(1, 0, 8'h09, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'h0A, 1, 0);
            check("alt stall in_ready", 32'(in_ready), 32'd0);
            check("alt stall ch0 unused", 32'(out0_valid), 32'd0);
            check("alt stall out1_data", 32'(out1_data), 32'h06);
        end
        step(1, 0, 8'h0A, 1, 1);
        check("alt release out1_data", 32'(out1_data), 32'h08);
        step(1, 0, 8'h0A, 1, 1);
        check("alt 0A on ch1", 32'(out1_data), 32'h0A);
        step(0, 0, 8'h00, 1, 1);

        // Reset mid-stream with two beats buffered per channel
        mode = 1'b0;
        step(1, 0, 8'hB0, 0, 0);
        step(1, 0, 8'hB1, 0, 0);
        step(1, 1, 8'hB2, 0, 0);
        step(1, 1, 8'hB3, 0, 0);
        rst = 1'b1; mode = 1'b1;
        step(1, 0, 8'hCC, 0, 0);
        check("mid rst out0_valid", 32'(out0_valid), 32'd0);
        check("mid rst out1_valid", 32'(out1_valid), 32'd0);
        check("mid rst cnt0", 32'(cnt0), 32'd0);
        check("mid rst cnt1", 32'(cnt1), 32'd0);
        rst = 1'b0;
        step(1, 1, 8'h77, 0, 0);
        check("post rst alt ch0", 32'(out0_valid), 32'd1);
        check("post rst alt data", 32'(out0_data), 32'h77);
        check("post rst ch1 empty", 32'(out1_valid), 32'd0);

        // Counter wrap on ch1
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, W'(8'hE0 + i), 1, 1);
            check("wrap cnt1", 32'(cnt1), 32'(wrap_exp[i]));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(24) == 0) mode = ~mode;
            step(1'($urandom_range(3) != 0), 1'($urandom), W'($urandom),
                 1'($urandom_range(3) != 0), 1'($urandom_range(2) != 0));
        end
        rst = 1'b0;
        step(0, 0, 8'h00, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux2_stream
